// File: rtl/wb_retire_queue.sv
// In-order write-back queue for the Beta pipeline: buffers MEM results, waits for load data
// returned in issue order, and retires one register-file write per cycle.
module wb_retire_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_y,
  input  logic [AW-1:0]    in_rc,
  input  logic             mem_rd_valid,
  input  logic [XLEN-1:0]  mem_rd_data,
  output logic             rf_we,
  output logic [AW-1:0]    rf_w_addr,
  output logic [XLEN-1:0]  rf_w_data,
  output logic             ld_pending,
  output logic             err_unexp_rd,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [1:0]    SelAlu  = 2'd0;
  localparam logic [1:0]    SelLd   = 2'd1;
  localparam logic [1:0]    SelPc   = 2'd2;
  localparam logic [1:0]    SelNone = 2'd3;
  localparam logic [AW-1:0] RegR31  = '1;

  logic [1:0]      sel_q  [DEPTH];
  logic [AW-1:0]   rc_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] dv_q;
  logic [PW-1:0]   head_q, tail_q;
  logic [PW:0]     cnt_q;

  logic            push, pop, fill, fill_found;
  logic [PW-1:0]   fill_idx, scan_idx;
  logic [XLEN-1:0] push_data;

  // Full/empty depend only on registered occupancy, so in_ready has no input-to-output path.
  assign in_ready = (cnt_q != (PW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (cnt_q != '0) && dv_q[head_q];
  assign fill     = mem_rd_valid && fill_found;

  assign ld_pending = fill_found;

  always_comb begin
    push_data = '0;
    case (in_sel)
      SelAlu:  push_data = in_y;
      SelPc:   push_data = in_pc;
      default: push_data = '0;
    endcase
  end

  // Oldest valid load still waiting for data, scanning from the head in program order.
  always_comb begin
    fill_found = 1'b0;
    fill_idx   = head_q;
    scan_idx   = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (!fill_found && ((PW+1)'(i) < cnt_q) && (sel_q[scan_idx] == SelLd) &&
          !dv_q[scan_idx]) begin
        fill_found = 1'b1;
        fill_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= '0;
      dv_q         <= '0;
      rf_we        <= 1'b0;
      rf_w_addr    <= '0;
      rf_w_data    <= '0;
      err_unexp_rd <= 1'b0;
      retired_cnt  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sel_q[i]  <= SelNone;
        rc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        sel_q[tail_q]  <= in_sel;
        rc_q[tail_q]   <= in_rc;
        data_q[tail_q] <= push_data;
        dv_q[tail_q]   <= (in_sel != SelLd);
        tail_q         <= tail_q + 1'b1;
      end

      // A pushed slot is never occupied, so it cannot collide with the fill target.
      if (fill) begin
        data_q[fill_idx] <= mem_rd_data;
        dv_q[fill_idx]   <= 1'b1;
      end

      if (mem_rd_valid && !fill_found) begin
        err_unexp_rd <= 1'b1;
      end

      if (pop) begin
        head_q      <= head_q + 1'b1;
        rf_we       <= (sel_q[head_q] != SelNone) && (rc_q[head_q] != RegR31);
        rf_w_addr   <= rc_q[head_q];
        rf_w_data   <= data_q[head_q];
        retired_cnt <= retired_cnt + 1'b1;
      end else begin
        rf_we <= 1'b0;
      end

      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Scoreboard bench for wb_retire_queue: expected register writes are queued at push time
// and checked in order whenever the DUT asserts rf_we.
module tb_wb_retire_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_y;
  logic [AW-1:0]    in_rc;
  logic             mem_rd_valid;
  logic [XLEN-1:0]  mem_rd_data;
  logic             rf_we;
  logic [AW-1:0]    rf_w_addr;
  logic [XLEN-1:0]  rf_w_data;
  logic             ld_pending;
  logic             err_unexp_rd;
  logic [CNT_W-1:0] retired_cnt;

  always #5 clk = ~clk;

  wb_retire_queue #(
    .XLEN (XLEN),
    .AW   (AW),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_pc       (in_pc),
    .in_y        (in_y),
    .in_rc       (in_rc),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data (mem_rd_data),
    .rf_we       (rf_we),
    .rf_w_addr   (rf_w_addr),
    .rf_w_data   (rf_w_data),
    .ld_pending  (ld_pending),
    .err_unexp_rd(err_unexp_rd),
    .retired_cnt (retired_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [AW+XLEN-1:0] exp_q[$];
  logic [XLEN-1:0]    rd_q[$];
  int unsigned        n_pushed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every observed write must be the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'(rf_we), 64'd0);
      end else begin
        logic [AW+XLEN-1:0] e;
        e = exp_q.pop_front();
        check("wb_write", 64'({rf_w_addr, rf_w_data}), 64'(e));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [AW-1:0] rc, input logic [XLEN-1:0] val);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("push_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_sel   = sel;
    in_rc    = rc;
    in_y     = (sel == 2'd0) ? val : $urandom;
    in_pc    = (sel == 2'd2) ? val : $urandom;
    if (sel == 2'd1) rd_q.push_back(val);
    if (sel != 2'd3 && rc != 5'd31) exp_q.push_back({rc, val});
    n_pushed++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic strobe();
    if (rd_q.size() == 0) begin
      check("strobe_no_data", 64'(rd_q.size()), 64'd1);
    end else begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = rd_q.pop_front();
      @(posedge clk);
      #1;
      mem_rd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(3);
    check("drain", 64'(exp_q.size()), 64'd0);
    check("retired_cnt", 64'(retired_cnt), 64'(n_pushed));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
    check({pfx, "_rf_we"}, 64'(rf_we), 64'd0);
    check({pfx, "_rf_w_addr"}, 64'(rf_w_addr), 64'd0);
    check({pfx, "_rf_w_data"}, 64'(rf_w_data), 64'd0);
    check({pfx, "_ld_pending"}, 64'(ld_pending), 64'd0);
    check({pfx, "_err"}, 64'(err_unexp_rd), 64'd0);
    check({pfx, "_retired"}, 64'(retired_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_sel       = '0;
    in_pc        = '0;
    in_y         = '0;
    in_rc        = '0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    idle(2);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    idle(1);

    // ALU write with exact latency
    push(2'd0, 5'd3, 32'h0000_00AA);
    @(posedge clk);
    #1;
    check("alu_we", 64'(rf_we), 64'd1);
    check("alu_addr", 64'(rf_w_addr), 64'd3);
    check("alu_data", 64'(rf_w_data), 64'hAA);
    check("alu_retired", 64'(retired_cnt), 64'd1);
    drain();

    // R31 and ST suppressed but counted; PC source written
    push(2'd0, 5'd31, 32'h5555_5555);
    push(2'd3, 5'd5, 32'h9999_9999);
    push(2'd2, 5'd7, 32'h0000_0100);
    drain();

    // Load blocks younger ALU until data returns
    push(2'd1, 5'd1, 32'h0000_1234);
    push(2'd0, 5'd2, 32'h0000_0007);
    check("ld_pending_set", 64'(ld_pending), 64'd1);
    idle(1);
    check("ld_blocks", 64'(rf_we), 64'd0);
    strobe();
    check("ld_pending_clr", 64'(ld_pending), 64'd0);
    @(posedge clk);
    #1;
    check("ld_first", 64'({rf_we, rf_w_addr, rf_w_data}), {31'd0, 1'b1, 5'd1, 32'h1234});
    @(posedge clk);
    #1;
    check("ld_second", 64'({rf_we, rf_w_addr, rf_w_data}), {31'd0, 1'b1, 5'd2, 32'h7});
    drain();

    // Full queue of loads; extra pushes refused
    for (int i = 0; i < 4; i++) push(2'd1, AW'(10 + i), XLEN'(32'h10 + i));
    check("full_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_rc    = 5'd20;
    in_y     = 32'h0000_0BAD;
    idle(2);
    in_valid = 1'b0;
    check("full_hold_ready", 64'(in_ready), 64'd0);
    check("full_ld_pending", 64'(ld_pending), 64'd1);
    strobe();
    check("full_before_pop", 64'(in_ready), 64'd0);
    strobe();
    check("ready_after_pop", 64'(in_ready), 64'd1);
    strobe();
    strobe();
    drain();

    // Unexpected read data on an empty queue
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'h0000_DEAD;
    idle(1);
    mem_rd_valid = 1'b0;
    check("err_set", 64'(err_unexp_rd), 64'd1);
    idle(5);
    check("err_sticky", 64'(err_unexp_rd), 64'd1);
    check("err_no_we", 64'(rf_we), 64'd0);
    check("err_retired", 64'(retired_cnt), 64'(n_pushed));

    // Reset with entries queued discards them
    push(2'd1, 5'd4, 32'h0000_0044);
    push(2'd0, 5'd5, 32'h0000_0055);
    push(2'd0, 5'd6, 32'h0000_0066);
    check("pre_rst_pending", 64'(ld_pending), 64'd1);
    rst_n = 1'b0;
    idle(1);
    exp_q.delete();
    rd_q.delete();
    n_pushed = 0;
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    idle(6);
    check("post_rst_no_we", 64'(rf_we), 64'd0);
    push(2'd0, 5'd8, 32'h0000_0088);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
